// File: rtl/decode_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage_pkg : CPU opcode, ALU mode and field-position defs  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package decode_stage_pkg;

   localparam int C_FIELD_W  = 4;
   localparam int C_RA_LSB   = 28;
   localparam int C_RB_LSB   = 24;
   localparam int C_RC_LSB   = 20;
   localparam int C_IMM_LSB  = 8;
   localparam int C_IMM_W    = 16;
   localparam int C_FUNC_LSB = 4;
   localparam int C_OP_LSB   = 0;

   typedef enum logic [3:0] {
      OP_ALUR   = 4'h0,
      OP_CMPR   = 4'h2,
      OP_SW     = 4'h5,
      OP_BRANCH = 4'h6,
      OP_ALUI   = 4'h8,
      OP_LW     = 4'h9,
      OP_CMPI   = 4'hA,
      OP_JAL    = 4'hB
   } opcode_e;

   typedef enum logic [1:0] {
      MODE_ALU = 2'b00,
      MODE_CMP = 2'b01,
      MODE_JAL = 2'b10
   } mode_e;

   function automatic logic [C_FIELD_W-1:0] get_field(logic [31:0] inst, int lsb);
      return inst[lsb +: C_FIELD_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_reg_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_scoreboard : per-register pending-write busy bits            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_scoreboard #(
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              set_en_i,
   input  logic [REG_AW-1:0] set_reg_i,
   input  logic              wb_clr_en_i,
   input  logic [REG_AW-1:0] wb_clr_reg_i,
   input  logic              rel_clr_en_i,
   input  logic [REG_AW-1:0] rel_clr_reg_i,
   input  logic [REG_AW-1:0] q1_reg_i,
   output logic              q1_busy_o,
   input  logic [REG_AW-1:0] q2_reg_i,
   output logic              q2_busy_o
);

   localparam int C_NREG = 2 ** REG_AW;

   logic [C_NREG-1:0] busy_q, busy_d, w_busy_eff;

   // Queries see the writeback clear in the same cycle; the set is applied last so it wins.
   always_comb begin
      w_busy_eff = busy_q;
      if (wb_clr_en_i) w_busy_eff[wb_clr_reg_i] = 1'b0;
      busy_d = w_busy_eff;
      if (rel_clr_en_i) busy_d[rel_clr_reg_i] = 1'b0;
      if (set_en_i) busy_d[set_reg_i] = 1'b1;
   end

   assign q1_busy_o = w_busy_eff[q1_reg_i];
   assign q2_busy_o = w_busy_eff[q2_reg_i];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage : instruction decode with hazard scoreboard         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rd,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [DATA_W-1:0] out_imm,
   output logic [5:0]        out_aluop,
   output logic [DATA_W-1:0] out_pc_next,
   output logic              out_br_en,
   output logic              out_rf_we,
   output logic              out_mem_we,
   output logic              out_src_reg,
   output logic              out_mem2reg,
   output logic              out_illegal,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_reg,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [31:0]       w_inst;
   opcode_e           w_op;
   mode_e             w_mode;
   logic [REG_AW-1:0] w_ra, w_rb, w_rc, w_rs1, w_rs2;
   logic              w_rf_we, w_mem_we, w_br_en, w_src_reg, w_mem2reg, w_illegal;
   logic              w_use1, w_use2, w_busy1, w_busy2;
   logic              w_hazard, w_load, w_release;
   logic [DATA_W-1:0] w_imm;

   logic              out_valid_q, out_valid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
   logic [DATA_W-1:0] imm_q, pc_next_q;
   logic [5:0]        aluop_q;
   logic              br_en_q, rf_we_q, mem_we_q, src_reg_q, mem2reg_q, illegal_q;

   assign w_inst = in_inst[31:0];
   assign w_op   = opcode_e'(w_inst[C_OP_LSB +: C_FIELD_W]);
   assign w_ra   = REG_AW'(get_field(w_inst, C_RA_LSB));
   assign w_rb   = REG_AW'(get_field(w_inst, C_RB_LSB));
   assign w_rc   = REG_AW'(get_field(w_inst, C_RC_LSB));
   assign w_imm  = {{(DATA_W-C_IMM_W){w_inst[C_IMM_LSB+C_IMM_W-1]}}, w_inst[C_IMM_LSB +: C_IMM_W]};

   // Source usage (w_use1/w_use2) refers to w_rs1/w_rs2, so stores and branches query ra,rb.
   always_comb begin
      w_rs1     = w_rb;
      w_rs2     = w_rc;
      w_mode    = MODE_ALU;
      w_rf_we   = 1'b1;
      w_mem_we  = 1'b0;
      w_br_en   = 1'b0;
      w_src_reg = 1'b0;
      w_mem2reg = 1'b0;
      w_illegal = 1'b0;
      w_use1    = 1'b1;
      w_use2    = 1'b0;
      case (w_op)
         OP_ALUR: begin
            w_src_reg = 1'b1;
            w_use2    = 1'b1;
         end
         OP_ALUI: begin
         end
         OP_LW: w_mem2reg = 1'b1;
         OP_CMPR: begin
            w_mode    = MODE_CMP;
            w_src_reg = 1'b1;
            w_use2    = 1'b1;
         end
         OP_CMPI: w_mode = MODE_CMP;
         OP_JAL:  w_mode = MODE_JAL;
         OP_SW: begin
            w_rs1    = w_ra;
            w_rs2    = w_rb;
            w_rf_we  = 1'b0;
            w_mem_we = 1'b1;
            w_use2   = 1'b1;
         end
         OP_BRANCH: begin
            w_rs1   = w_ra;
            w_rs2   = w_rb;
            w_mode  = MODE_CMP;
            w_br_en = 1'b1;
            w_rf_we = 1'b0;
            w_use2  = 1'b1;
         end
         default: begin
            w_illegal = 1'b1;
            w_rf_we   = 1'b0;
            w_use1    = 1'b0;
         end
      endcase
   end

   reg_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
      .clk          (clk),
      .reset_n      (reset_n),
      .set_en_i     (w_load && w_rf_we),
      .set_reg_i    (w_ra),
      .wb_clr_en_i  (wb_valid),
      .wb_clr_reg_i (wb_reg),
      .rel_clr_en_i (w_release),
      .rel_clr_reg_i(rd_q),
      .q1_reg_i     (w_rs1),
      .q1_busy_o    (w_busy1),
      .q2_reg_i     (w_rs2),
      .q2_busy_o    (w_busy2)
   );

   assign w_hazard  = in_valid && ((w_use1 && w_busy1) || (w_use2 && w_busy2));
   assign in_ready  = (!out_valid_q || out_ready) && !w_hazard && !flush;
   assign w_load    = in_valid && in_ready;
   // A flushed instruction that never left frees its destination again.
   assign w_release = flush && out_valid_q && rf_we_q && !out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (w_load)    out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
      stall_cnt_d = stall_cnt_q;
      if (w_hazard && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         stall_cnt_q <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         aluop_q     <= '0;
         pc_next_q   <= '0;
         br_en_q     <= 1'b0;
         rf_we_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         src_reg_q   <= 1'b0;
         mem2reg_q   <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
         if (w_load) begin
            rd_q      <= w_ra;
            rs1_q     <= w_rs1;
            rs2_q     <= w_rs2;
            imm_q     <= w_imm;
            aluop_q   <= {w_mode, w_inst[C_FUNC_LSB +: 4]};
            pc_next_q <= in_pc + DATA_W'(4);
            br_en_q   <= w_br_en;
            rf_we_q   <= w_rf_we;
            mem_we_q  <= w_mem_we;
            src_reg_q <= w_src_reg;
            mem2reg_q <= w_mem2reg;
            illegal_q <= w_illegal;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign stall_cnt   = stall_cnt_q;
   assign out_rd      = rd_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_imm     = imm_q;
   assign out_aluop   = aluop_q;
   assign out_pc_next = pc_next_q;
   assign out_br_en   = br_en_q;
   assign out_rf_we   = rf_we_q;
   assign out_mem_we  = mem_we_q;
   assign out_src_reg = src_reg_q;
   assign out_mem2reg = mem2reg_q;
   assign out_illegal = illegal_q;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32, instruction/PC width.
REQ-002 Parameter REG_AW, default 4, register address width; register file has 2**REG_AW entries.
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 in_pc / in_inst  in  DATA_W / DATA_W  fetched PC and instruction word.
REQ-008 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-009 out_rd, out_rs1, out_rs2  out  REG_AW each  write and read register selects.
REQ-010 out_imm  out  DATA_W  sign-extended imm[23:8].
REQ-011 out_aluop  out  6  {mode[1:0], func[3:0]}.
REQ-012 out_pc_next  out  DATA_W  in_pc+4, mod 2**DATA_W.
REQ-013 out_br_en, out_rf_we, out_mem_we, out_src_reg, out_mem2reg, out_illegal  out  1 each  control flags.
REQ-014 wb_valid / wb_reg  in  1 / REG_AW  writeback retiring one pending write.
REQ-015 flush  in  1  discard the held instruction (taken branch).
REQ-016 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-017 Fields: ra=inst[31:28], rb=inst[27:24], rc=inst[23:20], func=inst[7:4], op=inst[3:0].
REQ-018 Opcodes: ALUR 0x0, ALUI 0x8, LW 0x9, SW 0x5, CMPR 0x2, CMPI 0xA, BRANCH 0x6, JAL 0xB.
REQ-019 Default decode: rd=ra, rs1=rb, rs2=rc, mode=00, rf_we=1, all other flags 0.
REQ-020 ALUR: src_reg=1, sources rb,rc. ALUI: source rb. LW: mem2reg=1, source rb.
REQ-021 CMPR: mode=01, src_reg=1, sources rb,rc. CMPI: mode=01, source rb. JAL: mode=10, source rb.
REQ-022 SW: rs1=ra, rs2=rb, rf_we=0, mem_we=1, sources ra,rb. BRANCH: rs1=ra, rs2=rb, mode=01, br_en=1, rf_we=0, sources ra,rb.
REQ-023 Any other op: illegal=1, rf_we=0, mem_we=0, br_en=0; passed downstream as a NOP.
REQ-024 Output register loads on in_valid&&in_ready; latency exactly 1 cycle; outputs stable while out_valid&&!out_ready.
REQ-025 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-026 Scoreboard: one busy bit per register; set for rd when an rf_we=1 instruction loads.
REQ-027 wb_valid clears busy[wb_reg]; the clear is visible to the hazard check in the same cycle.
REQ-028 hazard = in_valid && any used source has busy=1 after the same-cycle wb clear.
REQ-029 Same-cycle set and clear of one register: set wins.
REQ-030 flush: out_valid->0 next edge; releases busy[out_rd] if the held instruction had rf_we=1 and was not accepted this cycle; no load that cycle.
REQ-031 stall_cnt increments on each cycle with hazard=1; holds at 2**CNT_W-1.
REQ-032 out_valid drops after out_valid&&out_ready when no new load occurs.

Reset
REQ-033 reset_n low asynchronously forces out_valid=0, all busy bits=0, stall_cnt=0, every other output to 0; in_ready=1 one cycle after deassertion.
REQ-034 Reset mid-handshake discards the held instruction; nothing is replayed.

Structure
REQ-035 Opcode constants, mode encodings and field bit positions live in a shared cpu package.
REQ-036 Scoreboard is one sub-module, reg_scoreboard (set, clear, query ports).

Verification
REQ-037 ALUR inst 0x12300000, pc 0x100 -> next cycle rd=1, rs1=2, rs2=3, src_reg=1, aluop=0x00, pc_next=0x104.
REQ-038 LW to r4, then ALUR reading r4 -> in_ready=0 and stall_cnt increments until wb_valid with wb_reg=4; issues in the wb cycle.
REQ-039 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; accepts one new instruction on release.
REQ-040 flush while holding LW to r5 -> out_valid=0, busy[5]=0; following read of r5 issues without stall.
REQ-041 op 0xF -> illegal=1, rf_we=0, no busy bit set; CNT_W=2 with 5 stall cycles -> stall_cnt=3.
REQ-042 reset_n pulsed low mid-stall -> all busy clear, out_valid=0, stall_cnt=0 immediately.
